// File: rtl/toast_mem_host.sv
`default_nettype none
// ============================================================================
//  Module      : toast_mem_host
//  Description : Memory-side responder for ToastCore. Loads a program image
//                over a valid/ready stream while holding the core in reset,
//                then serves IMEM/DMEM with one-cycle registered reads and
//                watches the tohost word for test completion or timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module toast_mem_host #(
    parameter int unsigned DEPTH_WORDS    = 16384,
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter int unsigned TIMEOUT_CYCLES = 2000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    // program image load stream
    input  logic        Load_valid,
    input  logic [31:0] Load_data,
    input  logic        Load_last,
    output logic        Load_ready,
    // core control
    output logic        Core_reset_n,
    // instruction fetch port
    input  logic [31:0] IMEM_addr,
    output logic [31:0] IMEM_data,
    // data port
    input  logic [31:0] DMEM_addr,
    input  logic [31:0] DMEM_wr_data,
    input  logic        DMEM_wr_en,
    input  logic        DMEM_rst,
    output logic [31:0] DMEM_rd_data,
    // completion status
    output logic        Done,
    output logic        Pass,
    output logic        Timeout,
    output logic [30:0] Fail_code,
    output logic [31:0] Cycle_count
);

    localparam int unsigned       c_AW           = $clog2(DEPTH_WORDS);
    localparam logic [c_AW-1:0]   c_PTR_ONE      = c_AW'(1);
    localparam logic [31:0]       c_TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [c_AW-1:0]   ptr_q, ptr_d;
    logic [31:0]       cycle_q, cycle_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
    logic [30:0]       fail_q, fail_d;
    logic              load_ready_q, load_ready_d;
    logic              core_rst_n_q, core_rst_n_d;
    logic [31:0]       imem_data_q, imem_data_d;
    logic [31:0]       dmem_data_q, dmem_data_d;

    // Unified instruction/data storage; contents survive reset
    logic [31:0]       mem [DEPTH_WORDS];

    // Single write port shared by the loader and the DMEM store path
    logic              mem_we;
    logic [c_AW-1:0]   mem_widx;
    logic [31:0]       mem_wdata;

    // Word indices; upper address bits are deliberately ignored (aliasing)
    logic [c_AW-1:0]   w_imem_idx;
    logic [c_AW-1:0]   w_dmem_idx;
    logic              w_load_fire;
    logic              w_tohost_wr;
    logic              w_tohost_done;
    logic              unused_addr_bits;

    assign w_imem_idx    = IMEM_addr[c_AW+1:2];
    assign w_dmem_idx    = DMEM_addr[c_AW+1:2];
    assign w_load_fire   = Load_valid && load_ready_q;
    assign w_tohost_wr   = DMEM_wr_en && (DMEM_addr == TOHOST_ADDR);
    assign w_tohost_done = w_tohost_wr && DMEM_wr_data[0];

    assign unused_addr_bits = ^{IMEM_addr[31:c_AW+2], IMEM_addr[1:0]};

    // Next-state, RAM write selection and status updates
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cycle_d   = cycle_q;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        fail_d    = fail_q;
        mem_we    = 1'b0;
        mem_widx  = ptr_q;
        mem_wdata = Load_data;

        case (state_q)
            ST_LOAD: begin
                if (w_load_fire) begin
                    mem_we = 1'b1;
                    // Pointer wraps naturally: an oversize image overwrites from word 0
                    ptr_d  = ptr_q + c_PTR_ONE;
                    if (Load_last) begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                cycle_d = cycle_q + 32'd1;
                // Stores to tohost never reach the RAM
                if (DMEM_wr_en && !w_tohost_wr) begin
                    mem_we    = 1'b1;
                    mem_widx  = w_dmem_idx;
                    mem_wdata = DMEM_wr_data;
                end
                // Completion takes priority over a coincident timeout
                if (w_tohost_done) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    if (DMEM_wr_data == 32'd1) begin
                        pass_d = 1'b1;
                    end else begin
                        fail_d = DMEM_wr_data[31:1];
                    end
                end else if (cycle_q == c_TIMEOUT_LAST) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_DONE;
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Output register next values; reads are only served while the core runs
    always_comb begin
        load_ready_d = (state_d == ST_LOAD);
        core_rst_n_d = (state_d == ST_RUN);
        imem_data_d  = 32'd0;
        dmem_data_d  = 32'd0;
        if (state_q == ST_RUN) begin
            imem_data_d = mem[w_imem_idx];
            if (!DMEM_rst) begin
                dmem_data_d = mem[w_dmem_idx];
            end
        end
    end

    // RAM write; no reset so the array maps onto block memory
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    // Control, status and read-data registers with asynchronous clear
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_LOAD;
            ptr_q        <= '0;
            cycle_q      <= 32'd0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            fail_q       <= 31'd0;
            load_ready_q <= 1'b0;
            core_rst_n_q <= 1'b0;
            imem_data_q  <= 32'd0;
            dmem_data_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cycle_q      <= cycle_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            fail_q       <= fail_d;
            load_ready_q <= load_ready_d;
            core_rst_n_q <= core_rst_n_d;
            imem_data_q  <= imem_data_d;
            dmem_data_q  <= dmem_data_d;
        end
    end

    assign Load_ready   = load_ready_q;
    assign Core_reset_n = core_rst_n_q;
    assign IMEM_data    = imem_data_q;
    assign DMEM_rd_data = dmem_data_q;
    assign Done         = done_q;
    assign Pass         = pass_q;
    assign Timeout      = timeout_q;
    assign Fail_code    = fail_q;
    assign Cycle_count  = cycle_q;

endmodule
`default_nettype wire

// File: tb/tb_toast_mem_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_toast_mem_host
//  Description : Self-checking bench for toast_mem_host (small RAM, short
//                timeout) using a run-vector table and a read scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_toast_mem_host;

    localparam logic [31:0] c_TOHOST = 32'h0000_1000;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        Load_valid = 1'b0;
    logic [31:0] Load_data = 32'd0;
    logic        Load_last = 1'b0;
    logic        Load_ready;
    logic        Core_reset_n;
    logic [31:0] IMEM_addr = 32'd0;
    logic [31:0] IMEM_data;
    logic [31:0] DMEM_addr = 32'd0;
    logic [31:0] DMEM_wr_data = 32'd0;
    logic        DMEM_wr_en = 1'b0;
    logic        DMEM_rst = 1'b0;
    logic [31:0] DMEM_rd_data;
    logic        Done;
    logic        Pass;
    logic        Timeout;
    logic [30:0] Fail_code;
    logic [31:0] Cycle_count;

    toast_mem_host #(
        .DEPTH_WORDS    (16),
        .TOHOST_ADDR    (c_TOHOST),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Load_valid   (Load_valid),
        .Load_data    (Load_data),
        .Load_last    (Load_last),
        .Load_ready   (Load_ready),
        .Core_reset_n (Core_reset_n),
        .IMEM_addr    (IMEM_addr),
        .IMEM_data    (IMEM_data),
        .DMEM_addr    (DMEM_addr),
        .DMEM_wr_data (DMEM_wr_data),
        .DMEM_wr_en   (DMEM_wr_en),
        .DMEM_rst     (DMEM_rst),
        .DMEM_rd_data (DMEM_rd_data),
        .Done         (Done),
        .Pass         (Pass),
        .Timeout      (Timeout),
        .Fail_code    (Fail_code),
        .Cycle_count  (Cycle_count)
    );

    always #5 Clk = ~Clk;

    // One RUN-phase vector: stimulus and the values expected after its edge
    typedef struct {
        int          grp;
        logic [31:0] imem_addr;
        logic [31:0] dmem_addr;
        logic [31:0] wdata;
        logic        we;
        logic        drst;
        logic [31:0] exp_imem;
        logic [31:0] exp_dmem;
        logic        exp_done;
    } vec_t;

    typedef struct {
        logic [31:0] imem;
        logic [31:0] dmem;
        logic        done;
        int          idx;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sb[$];
    logic [31:0] img[$];
    int          n_asserts = 0;
    int          n_fail    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Asynchronous reset assertion; outputs must clear without a clock edge
    task automatic do_reset();
        Load_valid = 1'b0;
        Load_last  = 1'b0;
        DMEM_wr_en = 1'b0;
        DMEM_rst   = 1'b0;
        Reset_n    = 1'b0;
        #2;
        chk("rst_load_ready", {31'd0, Load_ready},   32'd0);
        chk("rst_core_rst_n", {31'd0, Core_reset_n}, 32'd0);
        chk("rst_imem_data",  IMEM_data,             32'd0);
        chk("rst_dmem_data",  DMEM_rd_data,          32'd0);
        chk("rst_flags",      {29'd0, Done, Pass, Timeout}, 32'd0);
        chk("rst_fail_code",  {1'b0, Fail_code},     32'd0);
        chk("rst_cycles",     Cycle_count,           32'd0);
        tick();
        Reset_n = 1'b1;
    endtask

    // Streams img[] back-to-back; with_last marks the final word as last
    task automatic load_img(input bit with_last);
        int waited = 0;
        while (!Load_ready && waited < 10) begin
            tick();
            waited++;
        end
        chk("load_ready_seen", {31'd0, Load_ready}, 32'd1);
        for (int i = 0; i < img.size(); i++) begin
            Load_valid = 1'b1;
            Load_data  = img[i];
            Load_last  = with_last && (i == img.size() - 1);
            tick();
            if (i == 0 && img.size() > 1) begin
                chk("core_rst_n_during_load", {31'd0, Core_reset_n}, 32'd0);
            end
        end
        Load_valid = 1'b0;
        Load_last  = 1'b0;
        if (with_last) begin
            chk("core_rst_n_after_last", {31'd0, Core_reset_n}, 32'd1);
            chk("load_ready_after_last", {31'd0, Load_ready},   32'd0);
        end
    endtask

    // Applies every table row of a group; expectations go through the scoreboard
    task automatic run_rows(input int grp);
        exp_t e;
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].grp == grp) begin
                IMEM_addr    = tbl[i].imem_addr;
                DMEM_addr    = tbl[i].dmem_addr;
                DMEM_wr_data = tbl[i].wdata;
                DMEM_wr_en   = tbl[i].we;
                DMEM_rst     = tbl[i].drst;
                sb.push_back('{tbl[i].exp_imem, tbl[i].exp_dmem, tbl[i].exp_done, i});
                tick();
                e = sb.pop_front();
                chk($sformatf("vec%0d_imem", e.idx), IMEM_data,    e.imem);
                chk($sformatf("vec%0d_dmem", e.idx), DMEM_rd_data, e.dmem);
                chk($sformatf("vec%0d_done", e.idx), {31'd0, Done}, {31'd0, e.done});
            end
        end
        DMEM_wr_en = 1'b0;
        DMEM_rst   = 1'b0;
    endtask

    initial begin
        int n;

        // grp 0: basic RUN traffic after loading 0x11..0x44 (16-word RAM)
        //   grp  imem        dmem        wdata         we    rst   exp_imem      exp_dmem      done
        tbl.push_back('{0, 32'h0008, 32'h0000, 32'h0,        1'b0, 1'b0, 32'h33,       32'h11,       1'b0});
        tbl.push_back('{0, 32'h0000, 32'h2004, 32'hDEADBEEF, 1'b1, 1'b0, 32'h11,       32'h22,       1'b0});
        tbl.push_back('{0, 32'h0004, 32'h2004, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0});
        tbl.push_back('{0, 32'h0008, 32'h2004, 32'h0,        1'b0, 1'b1, 32'h33,       32'h0,        1'b0});
        tbl.push_back('{0, 32'h0008, 32'h0008, 32'h5,        1'b1, 1'b0, 32'h33,       32'h33,       1'b0});
        tbl.push_back('{0, 32'h0008, 32'h0008, 32'h0,        1'b0, 1'b0, 32'h5,        32'h5,        1'b0});
        tbl.push_back('{0, 32'h0000, c_TOHOST, 32'h4,        1'b1, 1'b0, 32'h11,       32'h11,       1'b0});
        tbl.push_back('{0, 32'h0000, c_TOHOST, 32'h1,        1'b1, 1'b0, 32'h11,       32'h11,       1'b1});
        // grp 1: after a mid-load reset and a one-word reload
        tbl.push_back('{1, 32'h0000, 32'h0004, 32'h0,        1'b0, 1'b0, 32'hB0,       32'hA2,       1'b0});
        tbl.push_back('{1, 32'h0004, 32'h0008, 32'h0,        1'b0, 1'b0, 32'hA2,       32'h5,        1'b0});
        // grp 2: after a 17-word image wrapped onto word 0
        tbl.push_back('{2, 32'h0000, 32'h0004, 32'h0,        1'b0, 1'b0, 32'h110,      32'h101,      1'b0});
        tbl.push_back('{2, 32'h003C, 32'h0040, 32'h0,        1'b0, 1'b0, 32'h10F,      32'h110,      1'b0});

        #1;
        do_reset();

        // Load, serve reads/writes, then complete with a pass
        img = '{32'h11, 32'h22, 32'h33, 32'h44};
        load_img(1'b1);
        run_rows(0);
        chk("pass_after_tohost1",    {31'd0, Pass},         32'd1);
        chk("failcode_after_tohost1", {1'b0, Fail_code},    32'd0);
        chk("timeout_after_tohost1", {31'd0, Timeout},      32'd0);
        chk("core_rst_n_in_done",    {31'd0, Core_reset_n}, 32'd0);
        chk("cycles_at_tohost1",     Cycle_count,           32'd8);

        // Failing completion code
        do_reset();
        img = '{32'h99};
        load_img(1'b1);
        DMEM_addr    = c_TOHOST;
        DMEM_wr_data = 32'h7;
        DMEM_wr_en   = 1'b1;
        tick();
        DMEM_wr_en = 1'b0;
        chk("done_after_tohost7",     {31'd0, Done},      32'd1);
        chk("pass_after_tohost7",     {31'd0, Pass},      32'd0);
        chk("failcode_after_tohost7", {1'b0, Fail_code},  32'd3);
        chk("cycles_at_tohost7",      Cycle_count,        32'd1);
        repeat (3) tick();
        chk("done_sticky",      {31'd0, Done},        32'd1);
        chk("failcode_sticky",  {1'b0, Fail_code},    32'd3);
        chk("cycles_frozen",    Cycle_count,          32'd1);
        chk("ready_low_in_done", {31'd0, Load_ready}, 32'd0);

        // Timeout with no completion write
        do_reset();
        img = '{32'h99};
        load_img(1'b1);
        n = 0;
        while (!Done && n < 30) begin
            tick();
            n++;
        end
        chk("timeout_edges",     n,                32'd10);
        chk("timeout_flag",      {31'd0, Timeout}, 32'd1);
        chk("timeout_done",      {31'd0, Done},    32'd1);
        chk("timeout_pass",      {31'd0, Pass},    32'd0);
        chk("timeout_cycles",    Cycle_count,      32'd10);

        // Completion on the final permitted cycle beats the timeout
        do_reset();
        img = '{32'h99};
        load_img(1'b1);
        repeat (9) tick();
        chk("pre_deadline_done",   {31'd0, Done}, 32'd0);
        chk("pre_deadline_cycles", Cycle_count,   32'd9);
        DMEM_addr    = c_TOHOST;
        DMEM_wr_data = 32'h1;
        DMEM_wr_en   = 1'b1;
        tick();
        DMEM_wr_en = 1'b0;
        chk("deadline_pass",    {31'd0, Pass},    32'd1);
        chk("deadline_timeout", {31'd0, Timeout}, 32'd0);
        chk("deadline_cycles",  Cycle_count,      32'd10);

        // Reset in the middle of a load, then a one-word reload
        do_reset();
        img = '{32'hA1, 32'hA2};
        load_img(1'b0);
        do_reset();
        img = '{32'hB0};
        load_img(1'b1);
        chk("reload_flags", {29'd0, Done, Pass, Timeout}, 32'd0);
        run_rows(1);

        // Oversize image wraps the load pointer
        do_reset();
        img.delete();
        for (int k = 0; k < 17; k++) img.push_back(32'h100 + k);
        load_img(1'b1);
        run_rows(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
